i2c_target: RTL and testbench

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_sync_edge.sv | 38 +++
 rtl/i2c_target.sv | 271 +++++++++++++++++++++++++++
 tb/tb_i2c_target.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
// Optional general-call support: I2C_TARGET_GENERAL_CALL_EN.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } tgt_state_t;

  localparam logic ACK_LVL  = 1'b0;
  localparam logic NACK_LVL = 1'b1;
  localparam logic SDA_REL  = 1'b1;

  localparam logic [6:0] GC_ADDR = 7'h00;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer with one delayed copy
// for rise/fall pulse generation.
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  always_comb begin
    s1_d   = din;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~prev_q;
  assign fall  = ~s2_q & prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, write sink, read source.
// Define I2C_TARGET_GENERAL_CALL_EN to also accept address 0 writes.
module i2c_target
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter logic [ADDR_WIDTH-1:0] TARGET_ADDR = 7'h42
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SCL_in,
  input  logic                  SDA_in,
  output logic                  SDA_out,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_req,
  output logic                  addr_match,
  output logic                  busy
);

  localparam int MAXW  = (ADDR_WIDTH > DATA_WIDTH) ?
                         ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = $clog2(MAXW + 1);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge u_scl (
    .clk  (clk),
    .rst  (rst),
    .din  (SCL_in),
    .level(scl_lvl),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  i2c_sync_edge u_sda (
    .clk  (clk),
    .rst  (rst),
    .din  (SDA_in),
    .level(sda_lvl),
    .rise (sda_rise),
    .fall (sda_fall)
  );

  tgt_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_sh_q, addr_sh_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic                  rw_q, rw_d;
  logic                  phase_q, phase_d;
  logic                  nack_q, nack_d;
  logic                  sda_out_q, sda_out_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tx_req_q, tx_req_d;
  logic                  match_q, match_d;
  logic                  busy_q, busy_d;

  logic                  start_det, stop_det;
  logic                  addr_hit;
  logic [DATA_WIDTH-1:0] nxt_byte;
  logic [DATA_WIDTH-1:0] rx_byte;

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign nxt_byte  = tx_valid ? tx_data : '1;
  assign rx_byte   = {rx_sh_q[DATA_WIDTH-2:0], sda_lvl};

`ifdef I2C_TARGET_GENERAL_CALL_EN
  assign addr_hit = (addr_sh_q == TARGET_ADDR) ||
                    ((addr_sh_q == ADDR_WIDTH'(GC_ADDR)) &&
                     !sda_lvl);
`else
  assign addr_hit = (addr_sh_q == TARGET_ADDR);
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_sh_d  = addr_sh_q;
    rx_sh_d    = rx_sh_q;
    tx_sh_d    = tx_sh_q;
    rw_d       = rw_q;
    phase_d    = phase_q;
    nack_d     = nack_q;
    sda_out_d  = sda_out_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    match_d    = match_q;
    busy_d     = busy_q;

    if (start_det) begin
      state_d   = ADDR;
      cnt_d     = '0;
      phase_d   = 1'b0;
      sda_out_d = SDA_REL;
      match_d   = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      state_d   = IDLE;
      cnt_d     = '0;
      phase_d   = 1'b0;
      sda_out_d = SDA_REL;
      match_d   = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: sda_out_d = SDA_REL;

        ADDR: begin
          if (scl_rise) begin
            if (cnt_q == CNT_W'(ADDR_WIDTH)) begin
              rw_d    = sda_lvl;
              cnt_d   = '0;
              phase_d = 1'b0;
              if (addr_hit) begin
                state_d = ADDR_ACK;
                match_d = 1'b1;
              end else begin
                state_d = IGNORE;
              end
            end else begin
              addr_sh_d = {addr_sh_q[ADDR_WIDTH-2:0], sda_lvl};
              cnt_d     = cnt_q + CNT_W'(1);
            end
          end
        end

        // First SCL fall drives the ACK, the next one closes it.
        ADDR_ACK: begin
          if (scl_fall && !phase_q) begin
            sda_out_d = ACK_LVL;
            phase_d   = 1'b1;
          end else if (scl_fall) begin
            phase_d = 1'b0;
            if (rw_q) begin
              sda_out_d = nxt_byte[DATA_WIDTH-1];
              tx_sh_d   = {nxt_byte[DATA_WIDTH-2:0], 1'b0};
              cnt_d     = CNT_W'(1);
              state_d   = RD_DATA;
            end else begin
              sda_out_d = SDA_REL;
              cnt_d     = '0;
              state_d   = WR_DATA;
            end
          end else if (scl_rise && phase_q && rw_q) begin
            tx_req_d = 1'b1;
          end
        end

        WR_DATA: begin
          if (scl_rise) begin
            rx_sh_d = rx_byte;
            if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
              cnt_d   = '0;
              phase_d = 1'b0;
              state_d = WR_ACK;
              nack_d  = !rx_ready;
              if (rx_ready) begin
                rx_data_d  = rx_byte;
                rx_valid_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end

        WR_ACK: begin
          if (scl_fall && !phase_q) begin
            sda_out_d = nack_q ? NACK_LVL : ACK_LVL;
            phase_d   = 1'b1;
          end else if (scl_fall) begin
            sda_out_d = SDA_REL;
            phase_d   = 1'b0;
            cnt_d     = '0;
            state_d   = nack_q ? IGNORE : WR_DATA;
          end
        end

        RD_DATA: begin
          if (scl_fall) begin
            if (cnt_q == CNT_W'(DATA_WIDTH)) begin
              sda_out_d = SDA_REL;
              cnt_d     = '0;
              phase_d   = 1'b0;
              state_d   = RD_ACK;
            end else begin
              sda_out_d = tx_sh_q[DATA_WIDTH-1];
              tx_sh_d   = {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
              cnt_d     = cnt_q + CNT_W'(1);
            end
          end
        end

        RD_ACK: begin
          if (scl_rise && !phase_q) begin
            if (sda_lvl == ACK_LVL) begin
              tx_req_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end else if (scl_fall && phase_q) begin
            phase_d   = 1'b0;
            sda_out_d = nxt_byte[DATA_WIDTH-1];
            tx_sh_d   = {nxt_byte[DATA_WIDTH-2:0], 1'b0};
            cnt_d     = CNT_W'(1);
            state_d   = RD_DATA;
          end
        end

        IGNORE: sda_out_d = SDA_REL;

        default: begin
          state_d   = IDLE;
          sda_out_d = SDA_REL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_sh_q  <= '0;
      rx_sh_q    <= '0;
      tx_sh_q    <= '0;
      rw_q       <= 1'b0;
      phase_q    <= 1'b0;
      nack_q     <= 1'b0;
      sda_out_q  <= SDA_REL;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      match_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_sh_q  <= addr_sh_d;
      rx_sh_q    <= rx_sh_d;
      tx_sh_q    <= tx_sh_d;
      rw_q       <= rw_d;
      phase_q    <= phase_d;
      nack_q     <= nack_d;
      sda_out_q  <= sda_out_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      match_q    <= match_d;
      busy_q     <= busy_d;
    end
  end

  assign SDA_out    = sda_out_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign tx_req     = tx_req_q;
  assign addr_match = match_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Scoreboard bench for i2c_target: bus tasks push observations,
// a monitor pops expectations and compares.
module tb_i2c_target;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_c = 1'b1;
  logic       sda_line;
  logic       sda_out;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_req;
  logic       addr_match;
  logic       busy;

  assign sda_line = sda_c & sda_out;

  always #5 clk = ~clk;

  i2c_target dut (
    .clk       (clk),
    .rst       (rst),
    .SCL_in    (scl),
    .SDA_in    (sda_line),
    .SDA_out   (sda_out),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_req    (tx_req),
    .addr_match(addr_match),
    .busy      (busy)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cur_test = 0;
  logic low_seen = 1'b0;

  logic [7:0] exp_rx_q[$];
  int         exp_tag_q[$];
  logic [8:0] exp_bus_q[$];
  string      exp_nm_q[$];
  logic [8:0] got_bus_q[$];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  always @(negedge clk) begin
    if (sda_out === 1'b0) low_seen = 1'b1;
    if (rx_valid === 1'b1) begin
      if (exp_rx_q.size() == 0) chk("rx_valid_unexp", 1, 0);
      else chk("rx_data", {24'h0, rx_data}, {24'h0, exp_rx_q.pop_front()});
    end
    if (tx_req === 1'b1) begin
      if (exp_tag_q.size() == 0) chk("tx_req_unexp", 1, 0);
      else chk("tx_req_test", cur_test, exp_tag_q.pop_front());
    end
    if (got_bus_q.size() > 0) begin
      logic [8:0] g;
      g = got_bus_q.pop_front();
      if (exp_bus_q.size() == 0) chk("bus_unexp", {23'h0, g}, 32'h1FF);
      else chk(exp_nm_q.pop_front(), {23'h0, g}, {23'h0, exp_bus_q.pop_front()});
    end
  end

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic expect_bus(input string nm, input logic [8:0] v);
    exp_bus_q.push_back(v);
    exp_nm_q.push_back(nm);
  endtask

  task automatic bus_start();
    sda_c = 1'b1; wq();
    scl = 1'b1; wq();
    sda_c = 1'b0; wq();
    scl = 1'b0; wq();
  endtask

  task automatic bus_stop();
    scl = 1'b0; sda_c = 1'b0; wq();
    scl = 1'b1; wq();
    sda_c = 1'b1; wq();
  endtask

  task automatic clk_bit(input logic b, output logic seen);
    sda_c = b; wq();
    scl = 1'b1; wq();
    seen = sda_line; wq();
    scl = 1'b0; wq();
  endtask

  task automatic write_byte(input logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
    clk_bit(1'b1, s);
    got_bus_q.push_back({8'h00, s});
  endtask

  task automatic read8();
    logic [7:0] d;
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    got_bus_q.push_back({1'b0, d});
  endtask

  task automatic send_bit(input logic b);
    logic s;
    clk_bit(b, s);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    chk("rst_sda_out", {31'h0, sda_out}, 1);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_addr_match", {31'h0, addr_match}, 0);
    chk("rst_rx_data", {24'h0, rx_data}, 0);
    chk("rst_rx_valid", {31'h0, rx_valid}, 0);
    chk("rst_tx_req", {31'h0, tx_req}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // write 0xA5 to own address
    cur_test = 1;
    exp_rx_q.push_back(8'hA5);
    bus_start();
    chk("t1_busy_start", {31'h0, busy}, 1);
    expect_bus("t1_addr_ack", 9'h000);
    write_byte(8'h84);
    chk("t1_addr_match", {31'h0, addr_match}, 1);
    expect_bus("t1_data_ack", 9'h000);
    write_byte(8'hA5);
    bus_stop();
    chk("t1_busy_stop", {31'h0, busy}, 0);
    chk("t1_match_stop", {31'h0, addr_match}, 0);

    // foreign address: never drive low
    cur_test = 2;
    low_seen = 1'b0;
    bus_start();
    expect_bus("t2_addr_nack", 9'h001);
    write_byte(8'h86);
    expect_bus("t2_data_nack", 9'h001);
    write_byte(8'h11);
    bus_stop();
    chk("t2_low_seen", {31'h0, low_seen}, 0);
    chk("t2_busy", {31'h0, busy}, 0);

    // read 0x3C then 0x5A, NACK the second
    cur_test = 3;
    tx_data = 8'h3C; tx_valid = 1'b1;
    exp_tag_q.push_back(3);
    exp_tag_q.push_back(3);
    bus_start();
    expect_bus("t3_addr_ack", 9'h000);
    write_byte(8'h85);
    expect_bus("t3_byte0", 9'h03C);
    read8();
    tx_data = 8'h5A;
    send_bit(1'b0);
    expect_bus("t3_byte1", 9'h05A);
    read8();
    send_bit(1'b1);
    low_seen = 1'b0;
    expect_bus("t3_ignore", 9'h0FF);
    read8();
    chk("t3_ignore_low", {31'h0, low_seen}, 0);
    bus_stop();

    // read with no valid data
    cur_test = 4;
    tx_valid = 1'b0; tx_data = 8'h12;
    exp_tag_q.push_back(4);
    bus_start();
    expect_bus("t4_addr_ack", 9'h000);
    write_byte(8'h85);
    expect_bus("t4_byte_ff", 9'h0FF);
    read8();
    send_bit(1'b1);
    bus_stop();

    // sink not ready: NACK and ignore
    cur_test = 5;
    bus_start();
    expect_bus("t5_addr_ack", 9'h000);
    write_byte(8'h84);
    rx_ready = 1'b0;
    expect_bus("t5_data_nack", 9'h001);
    write_byte(8'h77);
    rx_ready = 1'b1;
    expect_bus("t5_later_nack", 9'h001);
    write_byte(8'h12);
    bus_stop();

    // repeated START into read, then reset mid-byte
    cur_test = 6;
    tx_data = 8'hC3; tx_valid = 1'b1;
    exp_tag_q.push_back(6);
    exp_tag_q.push_back(6);
    bus_start();
    expect_bus("t6_w_ack", 9'h000);
    write_byte(8'h84);
    bus_start();
    chk("t6_busy_rs", {31'h0, busy}, 1);
    expect_bus("t6_r_ack", 9'h000);
    write_byte(8'h85);
    expect_bus("t6_byte0", 9'h0C3);
    read8();
    tx_data = 8'h00;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    sda_c = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_drive_low", {31'h0, sda_out}, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_release", {31'h0, sda_out}, 1);
    chk("t6_rst_busy", {31'h0, busy}, 0);
    rst = 1'b0;
    low_seen = 1'b0;
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    chk("t6_post_rst_low", {31'h0, low_seen}, 0);
    bus_stop();
    exp_rx_q.push_back(8'h5C);
    bus_start();
    expect_bus("t6_rec_addr", 9'h000);
    write_byte(8'h84);
    expect_bus("t6_rec_data", 9'h000);
    write_byte(8'h5C);
    bus_stop();

    repeat (10) @(negedge clk);
    chk("end_rx_left", exp_rx_q.size(), 0);
    chk("end_tag_left", exp_tag_q.size(), 0);
    chk("end_bus_left", exp_bus_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
